bus_trace_buffer: RTL and testbench
===================================

Name: bus_trace_buffer

Overview:
- Passive capture stage that sits directly downstream of the CPU bus. It snoops the CPU request signals and the memory response signals in parallel with memory_top.
- Each completed transaction (address, data, direction, size, latency, timeout flag) is stored in a circular buffer.
- An address trigger, followed by a post-trigger count, freezes the buffer so history can be drained through a pop port by the bench or a debug UART.
- It never drives the bus.

Parameters:
- DEPTH, 64, number of entries; must be a power of 2, minimum 4.
- POST, 8, entries committed after the trigger entry before the buffer freezes; range 0..DEPTH-1.
- TIMEOUT, 4096, cycles without a response before a timeout entry is forced; minimum 2, maximum 65535.

Ports:
- i_clk  in  1  system clock; all logic on the rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_req_DV  in  1  CPU request strobe, one cycle.
- i_req_address  in  32  request address.
- i_req_data  in  32  write data.
- i_req_write_notread  in  1  1 = write.
- i_req_bhw  in  3  byte/half/word size code.
- i_rsp_DV  in  1  memory response strobe.
- i_rsp_data  in  32  read data.
- i_trig_enable  in  1  arms the address trigger.
- i_trig_address  in  32  trigger match address (exact 32-bit compare).
- i_rearm  in  1  clears buffer, freeze and trigger; keeps sticky error flags.
- i_rd_en  in  1  pop request.
- o_rd_DV  out  1  pop data valid.
- o_rd_entry  out  85  {timeout[84], latency[83:68], bhw[67:65], write[64], data[63:32], address[31:0]}.
- o_count  out  $clog2(DEPTH)+1  entries held.
- o_triggered  out  1  trigger hit, waiting for post count.
- o_frozen  out  1  capture stopped.
- o_timeout  out  1  sticky; at least one timeout entry written.
- o_proto_err  out  1  sticky; request seen while already waiting.

Behaviour:
- Reset and rearm values: all outputs 0, pointers 0, FSM in IDLE. i_rearm does the same except o_timeout and o_proto_err hold their value.
- FSM IDLE: on i_req_DV, latch the request fields, set lat=0, go to WAIT. An i_rsp_DV in IDLE is ignored.
- FSM WAIT: lat increments every cycle.
  - Response at cycle N after the request cycle commits an entry with latency=N. Back-to-back gives latency 1.
  - The data field holds i_rsp_data for reads and the latched write data for writes.
  - If lat reaches TIMEOUT-1 with no response, commit with timeout=1 and latency=TIMEOUT, set o_timeout, go to IDLE.
  - i_rsp_DV and i_req_DV in the same cycle: commit the current entry, latch the new request, stay in WAIT with lat=0.
  - i_req_DV without i_rsp_DV: set o_proto_err, drop the new request, keep waiting.
- Commit (only when not frozen):
  - Write at wr_ptr, then wr_ptr+1 modulo DEPTH.
  - If o_count==DEPTH, the oldest entry is overwritten: rd_ptr+1 and o_count unchanged. Otherwise o_count+1.
  - While frozen, commits are discarded, but the FSM keeps running and timeouts still set o_timeout.
- Trigger:
  - A committed entry whose address equals i_trig_address, while i_trig_enable=1 and o_triggered=0, sets o_triggered and post=POST.
  - POST=0: freeze on that same commit.
  - Otherwise each later commit decrements post; the commit that makes post 0 sets o_frozen and clears o_triggered.
  - Later address matches while o_triggered=1 are ignored.
- Readout (only when frozen):
  - i_rd_en with o_count>0: the next cycle has o_rd_DV=1 and o_rd_entry = oldest entry; rd_ptr+1, o_count-1.
  - i_rd_en with o_count==0, or while not frozen: ignored, o_rd_DV stays 0.
  - o_rd_DV is a one-cycle pulse; o_rd_entry holds its value until the next pop.
- Reset asserted mid-transaction: the in-flight request is dropped and no entry is written. A response arriving after reset is ignored as an IDLE response.
- Latency field is 16 bits; it cannot overflow because TIMEOUT ≤ 65535.

Test Plan:
- Read at 0x00001000, response 3 cycles later with data 0xDEADBEEF -> after freeze and pop: address=0x1000, data=0xDEADBEEF, write=0, latency=3, timeout=0.
- Write to 0x2000, data 0x12345678, bhw=2, response 1 cycle later -> entry has data=0x12345678, write=1, bhw=2, latency=1.
- DEPTH=4, POST=0: 6 transactions to 0x10..0x60 with trigger on 0x60 -> o_frozen=1, o_count=4, pops return 0x30, 0x40, 0x50, 0x60, then a 5th pop gives no o_rd_DV.
- POST=2: trigger on 0x100, then 3 more transactions -> freeze after the 2nd; the 3rd is not stored; the last popped entry is the 2nd post-trigger entry.
- TIMEOUT=16: request with no response -> entry with timeout=1, latency=16, o_timeout=1; a response arriving later is ignored.
- Second request while in WAIT -> o_proto_err=1 and the first transaction completes normally. Then i_rearm -> o_count=0, o_frozen=0, o_proto_err still 1.

Source files
------------

// File: rtl/bus_trace_buffer.sv
// Passive bus snoop: records each completed CPU transaction into a circular buffer,
// freezes after an address trigger plus a post-trigger count, then drains via a pop port.
module bus_trace_buffer #(
    parameter int DEPTH   = 64,
    parameter int POST    = 8,
    parameter int TIMEOUT = 4096
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       i_req_DV,
    input  logic [31:0]                i_req_address,
    input  logic [31:0]                i_req_data,
    input  logic                       i_req_write_notread,
    input  logic [2:0]                 i_req_bhw,
    input  logic                       i_rsp_DV,
    input  logic [31:0]                i_rsp_data,
    input  logic                       i_trig_enable,
    input  logic [31:0]                i_trig_address,
    input  logic                       i_rearm,
    input  logic                       i_rd_en,
    output logic                       o_rd_DV,
    output logic [84:0]                o_rd_entry,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_triggered,
    output logic                       o_frozen,
    output logic                       o_timeout,
    output logic                       o_proto_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int LW = 16;
    localparam logic [CW-1:0] FULL     = CW'(DEPTH);
    localparam logic [AW-1:0] POST_N   = AW'(POST);
    localparam logic [LW-1:0] LAT_LAST = LW'(TIMEOUT - 1);
    localparam logic [LW-1:0] LAT_TO   = LW'(TIMEOUT);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t          state_q, state_d;
    logic [31:0]     addr_q, data_q;
    logic            write_q;
    logic [2:0]      bhw_q;
    logic [LW-1:0]   lat_q, lat_d;
    logic            latch;

    logic            commit, cm_timeout, proto_hit;
    logic [LW-1:0]   cm_lat;
    logic [31:0]     cm_data;
    logic [84:0]     cm_entry;

    logic [84:0]     mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr, post_cnt;
    logic            clear, store, trig_hit, pop;

    // Transaction tracker: at most one request outstanding.
    always_comb begin
        state_d    = state_q;
        lat_d      = lat_q + 16'd1;
        latch      = 1'b0;
        commit     = 1'b0;
        cm_timeout = 1'b0;
        cm_lat     = lat_q + 16'd1;
        cm_data    = write_q ? data_q : i_rsp_data;
        proto_hit  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_req_DV) begin
                    latch   = 1'b1;
                    lat_d   = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (i_rsp_DV) begin
                    commit = 1'b1;
                    if (i_req_DV) begin
                        latch = 1'b1;
                        lat_d = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else if (lat_q == LAT_LAST) begin
                    // Timed-out reads never saw read data, so record zero.
                    commit     = 1'b1;
                    cm_timeout = 1'b1;
                    cm_lat     = LAT_TO;
                    cm_data    = write_q ? data_q : 32'h0;
                    proto_hit  = i_req_DV;
                    state_d    = S_IDLE;
                end else if (i_req_DV) begin
                    proto_hit = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign cm_entry = {cm_timeout, cm_lat, bhw_q, write_q, cm_data, addr_q};

    always_ff @(posedge i_clk) begin
        if (i_reset || i_rearm) begin
            state_q <= S_IDLE;
            lat_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            write_q <= 1'b0;
            bhw_q   <= '0;
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
            if (latch) begin
                addr_q  <= i_req_address;
                data_q  <= i_req_data;
                write_q <= i_req_write_notread;
                bhw_q   <= i_req_bhw;
            end
        end
    end

    assign clear    = i_reset || i_rearm;
    assign store    = commit && !o_frozen && !clear;
    assign trig_hit = i_trig_enable && !o_triggered && (addr_q == i_trig_address);
    assign pop      = o_frozen && i_rd_en && (o_count != '0);

    always_ff @(posedge i_clk) begin
        if (store)
            mem[wr_ptr] <= cm_entry;
    end

    always_ff @(posedge i_clk) begin
        if (clear) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            o_count     <= '0;
            post_cnt    <= '0;
            o_triggered <= 1'b0;
            o_frozen    <= 1'b0;
            o_rd_DV     <= 1'b0;
            o_rd_entry  <= '0;
            if (i_reset) begin
                o_timeout   <= 1'b0;
                o_proto_err <= 1'b0;
            end
        end else begin
            o_rd_DV <= 1'b0;
            if (commit && cm_timeout)
                o_timeout <= 1'b1;
            if (proto_hit)
                o_proto_err <= 1'b1;
            if (store) begin
                wr_ptr <= wr_ptr + 1'b1;
                if (o_count == FULL)
                    rd_ptr <= rd_ptr + 1'b1;
                else
                    o_count <= o_count + 1'b1;
                if (trig_hit) begin
                    if (POST == 0) begin
                        o_frozen <= 1'b1;
                    end else begin
                        o_triggered <= 1'b1;
                        post_cnt    <= POST_N;
                    end
                end else if (o_triggered) begin
                    post_cnt <= post_cnt - 1'b1;
                    if (post_cnt == AW'(1)) begin
                        o_frozen    <= 1'b1;
                        o_triggered <= 1'b0;
                    end
                end
            end
            if (pop) begin
                o_rd_DV    <= 1'b1;
                o_rd_entry <= mem[rd_ptr];
                rd_ptr     <= rd_ptr + 1'b1;
                o_count    <= o_count - 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_bus_trace_buffer.sv
// Directed bench: two instances (DEPTH=4/POST=0 and DEPTH=8/POST=2) share the snooped bus.
module tb_bus_trace_buffer;
    logic        clk = 1'b0;
    logic        reset, req_dv, req_wr, rsp_dv, rearm;
    logic [31:0] req_addr, req_data, rsp_data, trig_addr;
    logic [2:0]  req_bhw;
    logic        te_a, te_b, rd_a, rd_b;

    logic        a_rd_dv, a_trig, a_frz, a_to, a_pe;
    logic [84:0] a_entry;
    logic [2:0]  a_cnt;
    logic        b_rd_dv, b_trig, b_frz, b_to, b_pe;
    logic [84:0] b_entry;
    logic [3:0]  b_cnt;

    int checks   = 0;
    int failures = 0;
    logic        dv;
    logic [84:0] e;

    always #5 clk = ~clk;

    bus_trace_buffer #(.DEPTH(4), .POST(0), .TIMEOUT(16)) dut_a (
        .i_clk(clk), .i_reset(reset), .i_req_DV(req_dv), .i_req_address(req_addr),
        .i_req_data(req_data), .i_req_write_notread(req_wr), .i_req_bhw(req_bhw),
        .i_rsp_DV(rsp_dv), .i_rsp_data(rsp_data), .i_trig_enable(te_a),
        .i_trig_address(trig_addr), .i_rearm(rearm), .i_rd_en(rd_a),
        .o_rd_DV(a_rd_dv), .o_rd_entry(a_entry), .o_count(a_cnt), .o_triggered(a_trig),
        .o_frozen(a_frz), .o_timeout(a_to), .o_proto_err(a_pe));

    bus_trace_buffer #(.DEPTH(8), .POST(2), .TIMEOUT(16)) dut_b (
        .i_clk(clk), .i_reset(reset), .i_req_DV(req_dv), .i_req_address(req_addr),
        .i_req_data(req_data), .i_req_write_notread(req_wr), .i_req_bhw(req_bhw),
        .i_rsp_DV(rsp_dv), .i_rsp_data(rsp_data), .i_trig_enable(te_b),
        .i_trig_address(trig_addr), .i_rearm(rearm), .i_rd_en(rd_b),
        .o_rd_DV(b_rd_dv), .o_rd_entry(b_entry), .o_count(b_cnt), .o_triggered(b_trig),
        .o_frozen(b_frz), .o_timeout(b_to), .o_proto_err(b_pe));

    task automatic chk(input string tag, input logic [84:0] got, input logic [84:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc();
    endtask

    task automatic req(input logic [31:0] a, input logic wr, input logic [31:0] d, input logic [2:0] bhw);
        req_dv = 1'b1; req_addr = a; req_wr = wr; req_data = d; req_bhw = bhw;
        cyc();
        req_dv = 1'b0;
    endtask

    task automatic rsp(input logic [31:0] d);
        rsp_dv = 1'b1; rsp_data = d;
        cyc();
        rsp_dv = 1'b0;
    endtask

    // Response arrives `gap` cycles after the request cycle.
    task automatic xact(input logic [31:0] a, input logic wr, input logic [31:0] d,
                        input logic [2:0] bhw, input int gap, input logic [31:0] rd);
        req(a, wr, d, bhw);
        idle(gap - 1);
        rsp(rd);
    endtask

    task automatic do_rearm();
        rearm = 1'b1;
        cyc();
        rearm = 1'b0;
    endtask

    task automatic pop_a(output logic v, output logic [84:0] ent);
        rd_a = 1'b1;
        cyc();
        v = a_rd_dv; ent = a_entry;
        rd_a = 1'b0;
        cyc();
    endtask

    task automatic pop_b(output logic v, output logic [84:0] ent);
        rd_b = 1'b1;
        cyc();
        v = b_rd_dv; ent = b_entry;
        rd_b = 1'b0;
        cyc();
    endtask

    initial begin
        reset = 1'b1; req_dv = 0; req_wr = 0; rsp_dv = 0; rearm = 0;
        req_addr = 0; req_data = 0; rsp_data = 0; trig_addr = 0; req_bhw = 0;
        te_a = 0; te_b = 0; rd_a = 0; rd_b = 0;
        idle(2);
        reset = 1'b0;
        cyc();
        chk("rst_count", a_cnt, 0);
        chk("rst_flags", {a_rd_dv, a_trig, a_frz, a_to, a_pe}, 0);
        chk("rst_entry", a_entry, 0);

        // Read, 3-cycle latency, freezes immediately (POST=0)
        te_a = 1; trig_addr = 32'h1000;
        xact(32'h1000, 0, 0, 3'd2, 3, 32'hDEADBEEF);
        chk("rd_frozen", a_frz, 1);
        chk("rd_count", a_cnt, 1);
        pop_a(dv, e);
        chk("rd_pop_dv", dv, 1);
        chk("rd_entry", e, {1'b0, 16'd3, 3'd2, 1'b0, 32'hDEADBEEF, 32'h1000});
        chk("rd_dv_pulse", a_rd_dv, 0);
        chk("rd_entry_hold", a_entry, {1'b0, 16'd3, 3'd2, 1'b0, 32'hDEADBEEF, 32'h1000});
        pop_a(dv, e);
        chk("rd_empty_pop", dv, 0);

        // Write: data field is the write data, not the response data
        do_rearm();
        trig_addr = 32'h2000;
        xact(32'h2000, 1, 32'h12345678, 3'd2, 1, 32'hFFFFFFFF);
        pop_a(dv, e);
        chk("wr_entry", e, {1'b0, 16'd1, 3'd2, 1'b1, 32'h12345678, 32'h2000});

        // Wraparound on DEPTH=4, trigger on the 6th transaction
        do_rearm();
        trig_addr = 32'h60;
        for (int i = 1; i <= 6; i++) begin
            xact(32'(i * 16), 0, 0, 3'd2, 1, 32'(32'hA0 + i));
            if (i == 5) begin
                chk("wrap_not_frozen", a_frz, 0);
                chk("wrap_full_count", a_cnt, 4);
            end
        end
        chk("wrap_frozen", a_frz, 1);
        chk("wrap_count", a_cnt, 4);
        for (int i = 3; i <= 6; i++) begin
            pop_a(dv, e);
            chk("wrap_pop_dv", dv, 1);
            chk("wrap_pop_addr", e[31:0], 32'(i * 16));
        end
        pop_a(dv, e);
        chk("wrap_5th_pop", dv, 0);

        // POST=2 on instance B
        do_rearm();
        te_a = 0; te_b = 1; trig_addr = 32'h100;
        xact(32'h100, 0, 0, 3'd2, 1, 32'h1);
        chk("post_trig", b_trig, 1);
        xact(32'h104, 0, 0, 3'd2, 1, 32'h2);
        chk("post_trig1", {b_trig, b_frz}, 2'b10);
        xact(32'h108, 0, 0, 3'd2, 1, 32'h3);
        chk("post_frz", {b_trig, b_frz}, 2'b01);
        xact(32'h10C, 0, 0, 3'd2, 2, 32'h4);
        chk("post_count", b_cnt, 3);
        pop_b(dv, e); chk("post_pop0", e[31:0], 32'h100);
        pop_b(dv, e); chk("post_pop1", e[31:0], 32'h104);
        pop_b(dv, e); chk("post_pop2", e[31:0], 32'h108);
        pop_b(dv, e); chk("post_pop3_dv", dv, 0);

        // Timeout (TIMEOUT=16)
        do_rearm();
        te_b = 0; te_a = 1; trig_addr = 32'h304;
        req(32'h300, 0, 0, 3'd1);
        idle(15);
        chk("to_before", {a_cnt, a_to}, {3'd0, 1'b0});
        cyc();
        chk("to_commit", {a_cnt, a_to}, {3'd1, 1'b1});
        idle(3);
        rsp(32'h55);
        chk("to_late_rsp", a_cnt, 1);
        xact(32'h304, 0, 0, 3'd2, 1, 32'h66);
        chk("to_count", a_cnt, 2);
        pop_a(dv, e);
        chk("to_fields", e[84:64], {1'b1, 16'd16, 3'd1, 1'b0});
        chk("to_addr", e[31:0], 32'h300);

        // Protocol error: second request while waiting is dropped
        do_rearm();
        trig_addr = 32'h400;
        chk("pe_clear", a_pe, 0);
        req(32'h400, 0, 0, 3'd2);
        req(32'h500, 0, 0, 3'd2);
        idle(1);
        rsp(32'h0000CAFE);
        chk("pe_set", a_pe, 1);
        chk("pe_frz_cnt", {a_frz, a_cnt}, {1'b1, 3'd1});
        pop_a(dv, e);
        chk("pe_entry", e, {1'b0, 16'd3, 3'd2, 1'b0, 32'h0000CAFE, 32'h400});
        do_rearm();
        chk("rearm_state", {a_cnt, a_frz, a_pe, a_to}, {3'd0, 1'b0, 1'b1, 1'b1});

        // Response and new request in the same cycle
        trig_addr = 32'h700;
        req(32'h600, 0, 0, 3'd2);
        idle(1);
        req_dv = 1; req_addr = 32'h700; req_wr = 0; req_bhw = 3'd2; rsp_dv = 1; rsp_data = 32'h11;
        cyc();
        req_dv = 0; rsp_dv = 0;
        rsp(32'h22);
        chk("b2b_count", {a_frz, a_cnt}, {1'b1, 3'd2});
        pop_a(dv, e);
        chk("b2b_first", e, {1'b0, 16'd2, 3'd2, 1'b0, 32'h11, 32'h600});
        pop_a(dv, e);
        chk("b2b_second", e, {1'b0, 16'd1, 3'd2, 1'b0, 32'h22, 32'h700});

        // Reset while a request is in flight
        te_a = 0;
        req(32'h800, 0, 0, 3'd2);
        idle(2);
        reset = 1;
        cyc();
        reset = 0;
        rsp(32'h99);
        idle(2);
        chk("mid_rst", {a_cnt, a_frz, a_to, a_pe}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
